// File: rtl/fft_power_spectrum_unit.sv
// FFT bin power stage: squares and sums each bin, tags it with index and
// frame-end, and buffers the results in a show-ahead ready/valid FIFO.
module fft_power_spectrum_unit #(
    parameter int DWL      = 16,
    parameter int AWL      = 5,
    parameter int OWL      = 32,
    parameter int FIFO_AWL = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic signed [DWL-1:0] i_DATA_R,
    input  logic signed [DWL-1:0] i_DATA_I,
    input  logic                  i_VALID,
    output logic [OWL-1:0]        o_POWER,
    output logic [AWL-1:0]        o_INDEX,
    output logic                  o_LAST,
    output logic                  o_VALID,
    input  logic                  i_READY,
    output logic                  OVERFLOW,
    output logic [7:0]            FRAME_CNT
);
    localparam int PW = 2 * DWL;
    localparam int EW = OWL + AWL + 1;

    logic                 accept;
    logic [AWL-1:0]       bin_idx;
    logic signed [PW-1:0] re_ext;
    logic signed [PW-1:0] im_ext;

    logic [PW-1:0]        s1_pr;
    logic [PW-1:0]        s1_pi;
    logic [AWL-1:0]       s1_idx;
    logic                 s1_last;
    logic                 s1_valid;

    logic [PW:0]          sum;
    logic [PW-1:0]        s2_pow;
    logic [AWL-1:0]       s2_idx;
    logic                 s2_last;
    logic                 s2_valid;

    logic [EW-1:0]        mem [2**FIFO_AWL];
    logic [EW-1:0]        head;
    logic [FIFO_AWL-1:0]  wr_ptr;
    logic [FIFO_AWL-1:0]  rd_ptr;
    logic [FIFO_AWL:0]    count;
    logic                 full;
    logic                 pop;
    logic                 push;

    assign accept = i_VALID & EN;
    assign re_ext = PW'(i_DATA_R);
    assign im_ext = PW'(i_DATA_I);

    always_ff @(posedge CLK) begin
        if (RST) begin
            bin_idx   <= '0;
            FRAME_CNT <= '0;
            s1_valid  <= 1'b0;
            s1_pr     <= '0;
            s1_pi     <= '0;
            s1_idx    <= '0;
            s1_last   <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_pr   <= re_ext * re_ext;
                s1_pi   <= im_ext * im_ext;
                s1_idx  <= bin_idx;
                s1_last <= &bin_idx;
                bin_idx <= bin_idx + AWL'(1);
                if (&bin_idx)
                    FRAME_CNT <= FRAME_CNT + 8'd1;
            end
        end
    end

    // Only the double-minimum corner sets bit PW-1; clamp it to all-ones.
    assign sum = {1'b0, s1_pr} + {1'b0, s1_pi};

    always_ff @(posedge CLK) begin
        if (RST) begin
            s2_valid <= 1'b0;
            s2_pow   <= '0;
            s2_idx   <= '0;
            s2_last  <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            s2_idx   <= s1_idx;
            s2_last  <= s1_last;
            if (sum[PW] | sum[PW-1])
                s2_pow <= '1;
            else
                s2_pow <= sum[PW-1:0];
        end
    end

    assign full    = count[FIFO_AWL];
    assign o_VALID = (count != '0);
    assign pop     = o_VALID & i_READY;
    assign push    = s2_valid & (~full | pop);

    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= {s2_last, s2_idx, s2_pow[PW-1 -: OWL]};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + FIFO_AWL'(1);
            if (pop)
                rd_ptr <= rd_ptr + FIFO_AWL'(1);
            if (push & ~pop)
                count <= count + (FIFO_AWL+1)'(1);
            else if (pop & ~push)
                count <= count - (FIFO_AWL+1)'(1);
            if (s2_valid & ~push)
                OVERFLOW <= 1'b1;
        end
    end

    // Head fields read as zero while empty so reset shows clean outputs.
    assign head    = mem[rd_ptr];
    assign o_POWER = o_VALID ? head[OWL-1:0] : '0;
    assign o_INDEX = o_VALID ? head[OWL +: AWL] : '0;
    assign o_LAST  = o_VALID ? head[EW-1] : 1'b0;

endmodule

// File: doc/fft_power_spectrum_unit.md
Name: fft_power_spectrum_unit

Overview:
Downstream consumer of the iterative FFT core output stream (o_DATA_R/o_DATA_I qualified by VALID, natural bin order, no backpressure).
- Computes the squared magnitude re^2+im^2 of each bin in a 2-stage pipeline.
- Tags each result with its bin index and a frame-end flag.
- Buffers results in a show-ahead FIFO with a ready/valid output, so a stalling sink does not lose bins until the FIFO overflows.

Parameters:
- DWL, 16: input real/imag word length, signed two's complement.
- AWL, 5: log2 of FFT length N; bin index width.
- OWL, 32: output power word length; 1 <= OWL <= 2*DWL.
- FIFO_AWL, 6: log2 of result FIFO depth (default 64 = two frames).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset; synchronous, active-high.
- EN  in  1  input accept enable.
- i_DATA_R  in  DWL  FFT bin real part, signed.
- i_DATA_I  in  DWL  FFT bin imaginary part, signed.
- i_VALID  in  1  bin present this cycle (FFT VALID).
- o_POWER  out  OWL  power of the bin at FIFO head.
- o_INDEX  out  AWL  bin index at FIFO head.
- o_LAST  out  1  head bin is index N-1.
- o_VALID  out  1  FIFO not empty.
- i_READY  in  1  sink accepts head.
- OVERFLOW  out  1  sticky: a result was dropped on a full FIFO.
- FRAME_CNT  out  8  count of completed input frames, wraps 255->0.

Behaviour:
- Reset: synchronous; all pipeline valids, FIFO pointers, index counter, OVERFLOW and FRAME_CNT clear to 0; o_POWER, o_INDEX, o_LAST = 0; o_VALID = 0. Reset mid-frame discards all in-flight and buffered data; the next accepted bin is index 0.
- Accept: a bin is accepted on a rising edge where i_VALID & EN = 1. With EN = 0 input is ignored, the index counter holds, and the pipeline and FIFO keep running.
- Index counter (AWL bits):
  - Attaches its current value to each accepted bin, then increments.
  - Wraps N-1 -> 0.
  - At the wrap, FRAME_CNT increments.
- Stage 1 (edge k, the accept edge): register pr = re*re and pi = im*im as 2*DWL-bit unsigned values, plus index, last and valid.
- Stage 2 (edge k+1): register s = pr + pi in 2*DWL+1 bits, then saturate to 2*DWL bits. Saturation occurs only when re = im = -2^(DWL-1).
- Output word: o_POWER = s[2*DWL-1 : 2*DWL-OWL], truncation with no rounding. With OWL = 2*DWL it is s exactly.
- FIFO write at edge k+2; with the FIFO empty, o_VALID is high in the cycle after edge k+2.
  - Minimum latency: 3 edges from accept to visible output.
  - Throughput: 1 bin per clock.
- FIFO:
  - Show-ahead: o_POWER, o_INDEX and o_LAST are valid whenever o_VALID = 1.
  - Pop on an edge with o_VALID & i_READY.
  - o_VALID is combinational from the occupancy count; data comes from registered/RAM read-ahead.
- Simultaneous push and pop:
  - FIFO full: the pop frees a slot, the push is accepted, nothing is dropped.
  - FIFO empty: the push is accepted and no pop occurs (o_VALID was 0).
- Overflow: a push on an edge with the FIFO full and no pop drops that result and sets OVERFLOW = 1 until RST. Index and frame counters are unaffected, so o_INDEX of later results stays correct.
- i_READY held low indefinitely: FIFO fills to 2^FIFO_AWL entries, then overflows per the rule above. Head data stays stable while o_VALID = 1 and i_READY = 0.

Test Plan:
- RST high for 2 cycles, then idle: o_VALID = 0, OVERFLOW = 0, FRAME_CNT = 0, o_POWER = 0.
- Single bin (3,4) accepted at edge k, i_READY = 1, OWL = 32: o_VALID high exactly in the cycle after edge k+2 with o_POWER = 25, o_INDEX = 0, o_LAST = 0; o_VALID low the next cycle.
- One frame of 32 bins (re = n, im = -n, n = 0..31) on consecutive cycles, i_READY = 1: 32 results in order with o_POWER = 2n^2, o_INDEX = n, o_LAST = 1 only at n = 31; FRAME_CNT = 1.
- Corner value (-32768,-32768), OWL = 32: o_POWER = 0xFFFFFFFF (saturated). Same input with OWL = 16: o_POWER = 0xFFFF. Input (-32768,0), OWL = 32: o_POWER = 0x40000000.
- i_READY = 0, three frames (96 bins) streamed: the first 64 results are retained, OVERFLOW rises on the 65th push. Then i_READY = 1: 64 results drained with o_INDEX cycling 0..31 twice; FRAME_CNT = 3.
- Reset mid-frame after 10 bins with 5 buffered: o_VALID drops the cycle after the reset edge. Then feed 1 bin: it emerges with o_INDEX = 0; FRAME_CNT = 0.
